// File: rtl/mult_rs_sched_if.sv
// Dispatch, snoop-bus and result-bus signals of the multiply reservation station.
// The master side is the dispatch unit / bus fabric, the slave side is the station.
interface mult_rs_sched_if;
    logic        disp_valid;
    logic        disp_ready;
    logic [7:0]  disp_src1_tag;
    logic [7:0]  disp_src2_tag;
    logic [31:0] disp_src1_val;
    logic [31:0] disp_src2_val;
    logic [7:0]  disp_tag;
    logic [39:0] loadbus;
    logic [39:0] addbus;
    logic [39:0] multbus;
    logic        cdb_req;
    logic        cdb_gnt;

    modport master (
        output disp_valid, disp_src1_tag, disp_src2_tag,
        output disp_src1_val, disp_src2_val,
        output loadbus, addbus, cdb_gnt,
        input  disp_ready, disp_tag, multbus, cdb_req
    );

    modport slave (
        input  disp_valid, disp_src1_tag, disp_src2_tag,
        input  disp_src1_val, disp_src2_val,
        input  loadbus, addbus, cdb_gnt,
        output disp_ready, disp_tag, multbus, cdb_req
    );
endinterface

// File: rtl/mult_rs_sched.sv
// Two-entry multiply reservation station with oldest-ready issue and a fixed-latency multiplier.
// Optional MULT_RS_WAKEUP_FWD_EN: an operand arriving on a bus can wake and issue its entry in that cycle.
module mult_rs_sched #(
    parameter int         MUL_LAT = 3,
    parameter logic [7:0] TAG_M0  = 8'h30
) (
    input  logic             clk,
    input  logic             rst,
    mult_rs_sched_if.slave   bus
);

    localparam int CW = $clog2(MUL_LAT + 1);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    // Entry storage: index [entry][source]
    logic [1:0]             valid_q;
    logic [1:0]             age_q;
    logic [1:0][1:0][7:0]   stag_q;
    logic [1:0][1:0][31:0]  sval_q;
    logic [1:0][1:0]        srdy_q;

    // Scheduler / multiplier state
    state_t                 state_q;
    logic [CW-1:0]          cnt_q;
    logic [31:0]            opa_q;
    logic [31:0]            opb_q;
    logic [7:0]             rtag_q;
    logic [39:0]            multbus_q;
    logic                   cdb_req_q;

    // Combinational helpers
    logic [1:0][1:0]        hit;
    logic [1:0][1:0][31:0]  hdat;
    logic [1:0][7:0]        dtag;
    logic [1:0][31:0]       dval;
    logic [1:0]             dhit;
    logic [1:0][31:0]       ddat;
    logic [1:0][1:0]        rdy_eff;
    logic [1:0][1:0][31:0]  opv;
    logic [1:0]             ent_rdy;
    logic                   issue;
    logic                   sel;
    logic                   free_idx;
    logic                   disp_fire;

    // Tag match against load, add and (granted) own result bus; tag 0 never matches
    function automatic logic [32:0] snoop(
        input logic [7:0]  tag,
        input logic [39:0] lb,
        input logic [39:0] ab,
        input logic [39:0] mb,
        input logic        gnt
    );
        logic [32:0] r;
        r = '0;
        if (tag != 8'h00) begin
            if (lb[39:32] == tag)
                r = {1'b1, lb[31:0]};
            else if (ab[39:32] == tag)
                r = {1'b1, ab[31:0]};
            else if (gnt && mb[39:32] == tag)
                r = {1'b1, mb[31:0]};
        end
        return r;
    endfunction

    // Snoop matches, effective readiness, issue selection and free-slot choice
    always_comb begin
        dtag = {bus.disp_src2_tag, bus.disp_src1_tag};
        dval = {bus.disp_src2_val, bus.disp_src1_val};
        hit     = '0;
        hdat    = '0;
        dhit    = '0;
        ddat    = '0;
        rdy_eff = '0;
        opv     = '0;
        for (int s = 0; s < 2; s++) begin
            {dhit[s], ddat[s]} = snoop(dtag[s], bus.loadbus,
                bus.addbus, multbus_q, bus.cdb_gnt);
        end
        for (int i = 0; i < 2; i++) begin
            for (int s = 0; s < 2; s++) begin
                {hit[i][s], hdat[i][s]} = snoop(stag_q[i][s],
                    bus.loadbus, bus.addbus, multbus_q, bus.cdb_gnt);
`ifdef MULT_RS_WAKEUP_FWD_EN
                rdy_eff[i][s] = srdy_q[i][s] | hit[i][s];
                opv[i][s] = srdy_q[i][s] ? sval_q[i][s] : hdat[i][s];
`else
                rdy_eff[i][s] = srdy_q[i][s];
                opv[i][s] = sval_q[i][s];
`endif
            end
        end
        ent_rdy   = valid_q & {&rdy_eff[1], &rdy_eff[0]};
        issue     = (state_q == S_IDLE) && (|ent_rdy);
        sel       = ent_rdy[1] && (!ent_rdy[0] || age_q[1]);
        free_idx  = valid_q[0];
        disp_fire = bus.disp_valid && !(&valid_q);
    end

    assign bus.disp_ready = ~(&valid_q);
    assign bus.disp_tag   = TAG_M0 + {7'd0, free_idx};
    assign bus.multbus    = multbus_q;
    assign bus.cdb_req    = cdb_req_q;

    // Entry allocation, operand wakeup, age tracking and release on issue
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            age_q   <= '0;
            stag_q  <= '0;
            sval_q  <= '0;
            srdy_q  <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                for (int s = 0; s < 2; s++) begin
                    if (valid_q[i] && !srdy_q[i][s] && hit[i][s]) begin
                        srdy_q[i][s] <= 1'b1;
                        sval_q[i][s] <= hdat[i][s];
                    end
                end
                if (issue && sel == 1'(i))
                    valid_q[i] <= 1'b0;
                if (disp_fire) begin
                    if (free_idx == 1'(i)) begin
                        valid_q[i] <= 1'b1;
                        age_q[i]   <= 1'b0;
                        for (int s = 0; s < 2; s++) begin
                            stag_q[i][s] <= dtag[s];
                            srdy_q[i][s] <= (dtag[s] == 8'h00) || dhit[s];
                            sval_q[i][s] <= (dtag[s] == 8'h00) ?
                                            dval[s] : ddat[s];
                        end
                    end else begin
                        age_q[i] <= valid_q[i];
                    end
                end
            end
        end
    end

    // Issue / multiply / result-hold state machine with registered bus outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            opa_q     <= '0;
            opb_q     <= '0;
            rtag_q    <= '0;
            multbus_q <= '0;
            cdb_req_q <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (issue) begin
                        opa_q   <= opv[sel][0];
                        opb_q   <= opv[sel][1];
                        rtag_q  <= TAG_M0 + {7'd0, sel};
                        cnt_q   <= CW'(MUL_LAT);
                        state_q <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (cnt_q == CW'(1)) begin
                        multbus_q <= {rtag_q, opa_q * opb_q};
                        cdb_req_q <= 1'b1;
                        state_q   <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                S_DONE: begin
                    if (bus.cdb_gnt) begin
                        multbus_q <= '0;
                        cdb_req_q <= 1'b0;
                        state_q   <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/mult_rs_sched.md
# mult_rs_sched

Two-entry multiply reservation station with issue scheduler for the dispatch unit. Accepts multiply ops from dispatch, snoops the load, add and multiply result buses for pending operand tags, and picks the oldest ready entry. It runs the selected op through an iterative multiplier of fixed latency. It then requests the shared result bus and broadcasts `{tag, product}` on `multbus`.

## Interface
- `MUL_LAT`, 3: multiplier busy cycles per op (≥1).
- `TAG_M0`, 8'h30: tag of entry 0; entry 1 is `TAG_M0+1` (8'h31).
- `clk` in 1: clock; all state updates on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `disp_valid` in 1: dispatch request.
- `disp_ready` out 1: a free entry exists.
- `disp_src1_tag`, `disp_src2_tag` in 8 each: producer tag; 8'h00 means the value is already valid.
- `disp_src1_val`, `disp_src2_val` in 32 each: operand value, used when its tag is 8'h00.
- `disp_tag` out 8: tag the next dispatch will receive.
- `loadbus`, `addbus` in 40 each: `[39:32]` tag (8'h00 = idle), `[31:0]` data.
- `multbus` out 40: result broadcast; 40'h0 when idle.
- `cdb_req` out 1: result pending.
- `cdb_gnt` in 1: result bus granted this cycle.

## Operation
- **Entry fields:** valid, age bit, and for each source a tag, value and ready flag.
- **Allocation:** a dispatch happens when `disp_valid && disp_ready`.
  - Lowest free entry is used; `disp_tag` shows that entry's tag.
  - Source is ready if its tag is 8'h00, or if that tag is on any bus in the same cycle; the bus data is captured.
  - New entry is marked younger than any existing entry.
- **Snoop:** every cycle, each valid entry compares each non-ready source tag against `loadbus`, `addbus` and its own `multbus` output (only while `cdb_gnt`).
  - On a match, capture the data and set ready.
  - Nonzero tags only.
- **Scheduler states:**
  - IDLE -> BUSY when some entry has both sources ready. If both entries qualify, the older one wins.
  - On issue: operands, tag and count = `MUL_LAT` are latched; the entry is freed.
  - BUSY: the counter decrements; at 1 -> DONE with the product latched.
  - DONE: `cdb_req`=1 and `multbus`=`{tag, product}`; this holds unchanged until `cdb_gnt`. On `cdb_gnt` -> IDLE.
- **Arithmetic:** product = low 32 bits of the unsigned 32×32 multiply.
- **Freed slot:** an entry freed at issue may be re-dispatched in the next cycle.
- **Simultaneous dispatch and snoop:** captures the bus value.
- **Own-result dependency:** a source tagged with this block's in-flight tag captures `multbus` at grant.
- **Reset:** aborts any in-flight op; no result is broadcast.

## Timing
- **Reset values:**
  - all entries invalid; state IDLE
  - `disp_ready`=1, `disp_tag`=8'h30
  - `cdb_req`=0, `multbus`=40'h0
- **Dispatch to issue:** an op dispatched with both sources ready at edge t issues at edge t+1.
- **Result timing:** DONE at edge t+1+`MUL_LAT`; `cdb_req` high during the following cycle.
- **Result hold:** held indefinitely without grant. The scheduler does not issue again until the result is granted and the state returns to IDLE.
- **Back-to-back:** with `cdb_gnt` tied high, minimum spacing is `MUL_LAT`+2 cycles.
- **Full:** `disp_ready`=0 when both entries are valid. An entry freed by issue at edge t raises `disp_ready` after t.

## Configuration
- **`MULT_RS_WAKEUP_FWD_EN` defined:**
  - An entry whose last operand arrives on a bus this cycle counts as ready for issue in the same cycle; the bus data feeds the multiplier operand directly.
  - Saves one cycle on wakeup.
  - Age ordering still applies.
- **Not defined:** operands are latched first; issue no earlier than the next cycle.

## Test plan
- **Basic multiply:** reset, then dispatch with src1=(00, 0x22) and src2=(00, 0x34). Required: `multbus`=`{8'h30, 32'h0000_06E8}` with `cdb_req` at cycle 1+`MUL_LAT`+1; cleared on `cdb_gnt`.
- **Tag wakeup:** dispatch M0 waiting on A0 and R2=0x4, and M1 waiting on LD0 and R1=0x22. Drive `loadbus`={40, 0x34}, then `addbus`={20, 0x1122}. Required: M1 issues first with result 0x6E8; M0 follows with result 0x4488.
- **Full:** two dispatches with tags pending. Required: `disp_ready`=0 and a third `disp_valid` is ignored; after wakeup and issue, `disp_ready`=1 and `disp_tag`=31 or 30 per the freed slot.
- **Grant stall:** hold `cdb_gnt`=0 for 5 cycles in DONE. Required: `multbus` stable; a ready second entry does not issue until after grant.
- **Own dependency:** M1 source tagged 30. Required: captures the product on the grant cycle and issues next; final result correct.
- **Reset mid-BUSY:** assert `rst` during the BUSY state. Required: `multbus`=0, `cdb_req`=0, all entries invalid immediately, with no result after release.
